// File: rtl/core_pkg.sv
// Shared definitions for the RV64I core: datapath width defaults and the
// bit positions of the 8-bit decoded control word.
package core_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int REG_AW_DEF = 5;
   localparam int CTRL_W     = 8;

   localparam int CTRL_REGWRITE = 7;
   localparam int CTRL_MEMTOREG = 6;
   localparam int CTRL_BRANCH   = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_ALUSRC   = 2;
   localparam int CTRL_ALUOP_HI = 1;
   localparam int CTRL_ALUOP_LO = 0;

   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

   function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the instruction in EX and the
// one in decode. rs2 is compared unconditionally, so the check is conservative.
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   output logic              hz
);

   logic rd_nonzero;
   logic rd_match;

   always_comb begin
      rd_nonzero = (ex_rd != '0);
      rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
      hz         = ex_mem_read && rd_nonzero && rd_match;
   end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating count of inserted load-use bubbles.
module id_ex_hazard_stage
   import core_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [REG_AW-1:0] IF_ID__Rs1,
   input  logic [REG_AW-1:0] IF_ID__Rs2,
   input  logic [REG_AW-1:0] IF_ID__Rd,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [3:0]        id_funct4,
   input  logic [7:0]        id_ctrl,
   output logic              pc_write,
   output logic              if_id_write,
   output logic [REG_AW-1:0] ID_EX__Rs1,
   output logic [REG_AW-1:0] ID_EX__Rs2,
   output logic [REG_AW-1:0] ID_EX__Rd,
   output logic [DATA_W-1:0] ID_EX__PC,
   output logic [DATA_W-1:0] ID_EX__RD1,
   output logic [DATA_W-1:0] ID_EX__RD2,
   output logic [DATA_W-1:0] ID_EX__Imm,
   output logic [3:0]        ID_EX__Funct4,
   output logic [7:0]        ID_EX__Ctrl,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [REG_AW-1:0] rs1_q, rs1_d;
   logic [REG_AW-1:0] rs2_q, rs2_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [3:0]        funct4_q, funct4_d;
   logic [7:0]        ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic              hz;

   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_load_use_detect (
      .ex_mem_read (ctrl_is_load(ctrl_q)),
      .ex_rd       (rd_q),
      .id_rs1      (IF_ID__Rs1),
      .id_rs2      (IF_ID__Rs2),
      .hz          (hz)
   );

   // A flush overrides the stall: the decode instruction is wrong-path anyway.
   always_comb begin
      pc_write    = !hz || flush;
      if_id_write = !hz || flush;
   end

   always_comb begin
      rs1_d         = IF_ID__Rs1;
      rs2_d         = IF_ID__Rs2;
      rd_d          = IF_ID__Rd;
      pc_d          = id_pc;
      rd1_d         = id_rd1;
      rd2_d         = id_rd2;
      imm_d         = id_imm;
      funct4_d      = id_funct4;
      ctrl_d        = id_ctrl;
      stall_count_d = stall_count_q;
      if (flush || hz) begin
         ctrl_d = CTRL_BUBBLE;
      end
      // Only genuine stalls are counted; a flushed hazard costs no extra cycle.
      if (hz && !flush && (stall_count_q != CNT_MAX)) begin
         stall_count_d = stall_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         pc_q          <= '0;
         rd1_q         <= '0;
         rd2_q         <= '0;
         imm_q         <= '0;
         funct4_q      <= '0;
         ctrl_q        <= '0;
         stall_count_q <= '0;
      end else begin
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rd_q          <= rd_d;
         pc_q          <= pc_d;
         rd1_q         <= rd1_d;
         rd2_q         <= rd2_d;
         imm_q         <= imm_d;
         funct4_q      <= funct4_d;
         ctrl_q        <= ctrl_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      ID_EX__Rs1    = rs1_q;
      ID_EX__Rs2    = rs2_q;
      ID_EX__Rd     = rd_q;
      ID_EX__PC     = pc_q;
      ID_EX__RD1    = rd1_q;
      ID_EX__RD2    = rd2_q;
      ID_EX__Imm    = imm_q;
      ID_EX__Funct4 = funct4_q;
      ID_EX__Ctrl   = ctrl_q;
      stall_count   = stall_count_q;
   end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: a wide-counter and a 2-bit-counter instance share
// stimulus; a behavioural model is compared every cycle, plus directed literal checks.
module tb_id_ex_hazard_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [4:0]  rs1, rs2, rd;
   logic [63:0] pc, rd1, rd2, imm;
   logic [3:0]  funct4;
   logic [7:0]  ctrl;

   logic        pcw_a, ifw_a, pcw_b, ifw_b;
   logic [4:0]  o_rs1_a, o_rs2_a, o_rd_a, o_rs1_b, o_rs2_b, o_rd_b;
   logic [63:0] o_pc_a, o_rd1_a, o_rd2_a, o_imm_a, o_pc_b, o_rd1_b, o_rd2_b, o_imm_b;
   logic [3:0]  o_f4_a, o_f4_b;
   logic [7:0]  o_ctrl_a, o_ctrl_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_hazard_stage #(.DATA_W(64), .REG_AW(5), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .IF_ID__Rs1(rs1), .IF_ID__Rs2(rs2), .IF_ID__Rd(rd),
      .id_pc(pc), .id_rd1(rd1), .id_rd2(rd2), .id_imm(imm),
      .id_funct4(funct4), .id_ctrl(ctrl),
      .pc_write(pcw_a), .if_id_write(ifw_a),
      .ID_EX__Rs1(o_rs1_a), .ID_EX__Rs2(o_rs2_a), .ID_EX__Rd(o_rd_a),
      .ID_EX__PC(o_pc_a), .ID_EX__RD1(o_rd1_a), .ID_EX__RD2(o_rd2_a), .ID_EX__Imm(o_imm_a),
      .ID_EX__Funct4(o_f4_a), .ID_EX__Ctrl(o_ctrl_a), .stall_count(cnt_a)
   );

   id_ex_hazard_stage #(.DATA_W(64), .REG_AW(5), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .IF_ID__Rs1(rs1), .IF_ID__Rs2(rs2), .IF_ID__Rd(rd),
      .id_pc(pc), .id_rd1(rd1), .id_rd2(rd2), .id_imm(imm),
      .id_funct4(funct4), .id_ctrl(ctrl),
      .pc_write(pcw_b), .if_id_write(ifw_b),
      .ID_EX__Rs1(o_rs1_b), .ID_EX__Rs2(o_rs2_b), .ID_EX__Rd(o_rd_b),
      .ID_EX__PC(o_pc_b), .ID_EX__RD1(o_rd1_b), .ID_EX__RD2(o_rd2_b), .ID_EX__Imm(o_imm_b),
      .ID_EX__Funct4(o_f4_b), .ID_EX__Ctrl(o_ctrl_b), .stall_count(cnt_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The EX-side instruction as the pipeline should hold it, plus the number of
   // real stall cycles since reset (unbounded; saturation applied when compared).
   logic        m_valid = 1'b0;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
   logic [3:0]  m_f4;
   logic [7:0]  m_ctrl;
   int          m_stalls;

   function automatic logic model_stall();
      // decode uses a register that a load in EX has not yet produced
      return m_ctrl[3] && (m_rd != 5'd0) && (m_rd == rs1 || m_rd == rs2);
   endfunction

   always @(posedge clk) begin
      logic stall_now;
      stall_now = m_valid && model_stall();
      if (reset) begin
         m_valid = 1'b1;
         {m_rs1, m_rs2, m_rd} = '0;
         {m_pc, m_rd1, m_rd2, m_imm} = '0;
         m_f4 = '0; m_ctrl = '0; m_stalls = 0;
      end else if (m_valid) begin
         m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
         m_pc = pc; m_rd1 = rd1; m_rd2 = rd2; m_imm = imm; m_f4 = funct4;
         m_ctrl = (flush || stall_now) ? 8'h00 : ctrl;
         if (stall_now && !flush) m_stalls++;
      end
   end

   // One compare process: every cycle, after inputs for the cycle are applied.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (m_valid) begin
            logic exp_pcw;
            exp_pcw = !model_stall() || flush;
            chk("pc_write_a", 64'(pcw_a), 64'(exp_pcw));
            chk("if_id_write_a", 64'(ifw_a), 64'(exp_pcw));
            chk("pc_write_b", 64'(pcw_b), 64'(exp_pcw));
            chk("rs1", 64'(o_rs1_a), 64'(m_rs1));
            chk("rs2", 64'(o_rs2_a), 64'(m_rs2));
            chk("rd", 64'(o_rd_a), 64'(m_rd));
            chk("pc", o_pc_a, m_pc);
            chk("rd1", o_rd1_a, m_rd1);
            chk("rd2", o_rd2_a, m_rd2);
            chk("imm", o_imm_a, m_imm);
            chk("funct4", 64'(o_f4_a), 64'(m_f4));
            chk("ctrl_a", 64'(o_ctrl_a), 64'(m_ctrl));
            chk("ctrl_b", 64'(o_ctrl_b), 64'(m_ctrl));
            chk("rd_b", 64'(o_rd_b), 64'(m_rd));
            chk("cnt_a", 64'(cnt_a), 64'((m_stalls > 65535) ? 65535 : m_stalls));
            chk("cnt_b", 64'(cnt_b), 64'((m_stalls > 3) ? 3 : m_stalls));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] c, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic fl);
      ctrl = c; rs1 = s1; rs2 = s2; rd = d; flush = fl;
      pc = {$urandom, $urandom}; rd1 = {$urandom, $urandom};
      rd2 = {$urandom, $urandom}; imm = {$urandom, $urandom};
      funct4 = 4'($urandom);
   endtask

   initial begin
      reset = 1'b1;
      drive(8'hFF, 5'd3, 5'd4, 5'd5, 1'b0);
      cyc();
      cyc();
      chk("reset_ctrl", 64'(o_ctrl_a), 64'h0);
      chk("reset_pc", o_pc_a, 64'h0);
      chk("reset_rd", 64'(o_rd_a), 64'h0);
      chk("reset_cnt", 64'(cnt_a), 64'h0);

      reset = 1'b0;
      drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc();
      #1 chk("post_reset_pc_write", 64'(pcw_a), 64'h1);

      // pass-through
      drive(8'h82, 5'd5, 5'd6, 5'd7, 1'b0);
      cyc();
      chk("pass_ctrl", 64'(o_ctrl_a), 64'h82);
      chk("pass_rd", 64'(o_rd_a), 64'h7);
      #1 chk("pass_pc_write", 64'(pcw_a), 64'h1);

      // load-use: ld x5 then add using x5
      drive(8'h88, 5'd1, 5'd2, 5'd5, 1'b0);
      cyc();
      drive(8'h82, 5'd5, 5'd9, 5'd8, 1'b0);
      #1 chk("lu_pc_write", 64'(pcw_a), 64'h0);
      chk("lu_if_id_write", 64'(ifw_a), 64'h0);
      cyc();
      chk("lu_bubble_ctrl", 64'(o_ctrl_a), 64'h0);
      chk("lu_cnt", 64'(cnt_a), 64'h1);
      #1 chk("lu_release", 64'(pcw_a), 64'h1);
      cyc();
      chk("lu_add_ctrl", 64'(o_ctrl_a), 64'h82);
      chk("lu_add_rd", 64'(o_rd_a), 64'h8);

      // load into x0 never stalls
      drive(8'h88, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc();
      drive(8'h82, 5'd0, 5'd0, 5'd9, 1'b0);
      #1 chk("x0_pc_write", 64'(pcw_a), 64'h1);
      cyc();
      chk("x0_cnt", 64'(cnt_a), 64'h1);
      chk("x0_ctrl", 64'(o_ctrl_a), 64'h82);

      // flush and hazard together
      drive(8'h88, 5'd1, 5'd2, 5'd5, 1'b0);
      cyc();
      drive(8'h82, 5'd5, 5'd0, 5'd9, 1'b1);
      #1 chk("fl_pc_write", 64'(pcw_a), 64'h1);
      cyc();
      chk("fl_ctrl", 64'(o_ctrl_a), 64'h0);
      chk("fl_cnt", 64'(cnt_a), 64'h1);

      // five load-use pairs: small counter sticks at 3
      for (int i = 0; i < 5; i++) begin
         drive(8'h88, 5'd1, 5'd2, 5'd5, 1'b0);
         cyc();
         drive(8'h82, 5'd0, 5'd5, 5'd9, 1'b0);
         cyc();
      end
      chk("sat_cnt_b", 64'(cnt_b), 64'h3);
      chk("sat_cnt_a", 64'(cnt_a), 64'h6);

      // reset in the middle of a stall
      drive(8'h88, 5'd1, 5'd2, 5'd5, 1'b0);
      cyc();
      drive(8'h82, 5'd5, 5'd0, 5'd9, 1'b0);
      #1 chk("mid_stall_pc_write", 64'(pcw_a), 64'h0);
      reset = 1'b1;
      cyc();
      chk("mid_reset_cnt", 64'(cnt_b), 64'h0);
      chk("mid_reset_ctrl", 64'(o_ctrl_a), 64'h0);
      reset = 1'b0;
      #1 chk("mid_reset_release", 64'(pcw_a), 64'h1);
      cyc();
      chk("mid_reset_advance", 64'(o_ctrl_a), 64'h82);

      // randomized traffic with a small register range to force collisions
      for (int i = 0; i < 600; i++) begin
         logic [7:0] c;
         c = 8'($urandom);
         c[3] = ($urandom_range(0, 1) == 1);
         drive(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
         reset = ($urandom_range(0, 49) == 0);
         cyc();
      end
      reset = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
